gcd_job_sequencer: RTL and testbench



---
 rtl/gcd_job_sequencer_if.sv | 32 +++
 rtl/gcd_job_sequencer.sv | 125 ++++++++++++
 tb/tb_gcd_job_sequencer.sv | 477 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_job_sequencer_if.sv
// Handshake bundle between the job producer/consumer, the GCD core and the sequencer.
// master is the sequencer's view; slave is the surrounding environment's view.
interface gcd_job_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             go;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             done;
  logic [WIDTH-1:0] gcd_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_gcd;
  logic             out_bypass;
  logic [CNT_W-1:0] out_cycles;
  logic             busy;

  modport master (
    input  in_valid, in_a, in_b, done, gcd_in, out_ready,
    output in_ready, go, op_a, op_b, out_valid, out_gcd, out_bypass, out_cycles, busy
  );

  modport slave (
    output in_valid, in_a, in_b, done, gcd_in, out_ready,
    input  in_ready, go, op_a, op_b, out_valid, out_gcd, out_bypass, out_cycles, busy
  );
endinterface

// File: rtl/gcd_job_sequencer.sv
// Buffers operand pairs, launches them one at a time on the GCD core and holds each
// result until accepted; zero-operand pairs are answered locally without the core.
module gcd_job_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input logic                 clk,
  input logic                 rst,
  gcd_job_sequencer_if.master bus
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LAUNCH = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] fifo_a [DEPTH];
  logic [WIDTH-1:0] fifo_b [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head_a;
  logic [WIDTH-1:0] head_b;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic [WIDTH-1:0] gcd_q;
  logic             bypass_q;
  logic [CNT_W-1:0] cycles_q;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign push    = bus.in_valid && bus.in_ready;
  assign pop     = (state == IDLE) && !empty;
  assign head_a  = fifo_a[rd_ptr[PTR_W-1:0]];
  assign head_b  = fifo_b[rd_ptr[PTR_W-1:0]];
  assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);

  assign bus.in_ready   = !full && !rst;
  assign bus.go         = (state == LAUNCH);
  assign bus.out_valid  = (state == HOLD);
  assign bus.busy       = (state != IDLE);
  assign bus.op_a       = op_a_q;
  assign bus.op_b       = op_b_q;
  assign bus.out_gcd    = gcd_q;
  assign bus.out_bypass = bypass_q;
  assign bus.out_cycles = cycles_q;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wr_ptr[PTR_W-1:0]] <= bus.in_a;
      fifo_b[wr_ptr[PTR_W-1:0]] <= bus.in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  // Operands change only on a pop, so they stay stable for the core from LAUNCH to done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      gcd_q    <= '0;
      bypass_q <= 1'b0;
      cycles_q <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            op_a_q <= head_a;
            op_b_q <= head_b;
            // The core never terminates on a zero operand; gcd(x,0)=x answers it here.
            if (head_a == '0 || head_b == '0) begin
              gcd_q    <= head_a | head_b;
              bypass_q <= 1'b1;
              cycles_q <= '0;
              state    <= HOLD;
            end else begin
              state <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (bus.done) begin
            gcd_q    <= bus.gcd_in;
            bypass_q <= 1'b0;
            cycles_q <= cnt_inc;
            state    <= HOLD;
          end else begin
            cnt <= cnt_inc;
          end
        end
        HOLD: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Bench for gcd_job_sequencer: behavioural GCD core, scoreboard queue of expected results,
// and one task per scenario.
module tb_gcd_job_sequencer;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  typedef struct packed {
    logic [WIDTH-1:0] gcd;
    logic [CNT_W-1:0] cycles;
    logic             bypass;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gcd_job_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bif ();

  gcd_job_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.master)
  );

  exp_t             exp_q[$];
  int               n_cmp = 0;
  int               n_bad = 0;
  int               n_out = 0;
  int               n_go = 0;
  int               last_go = -1;
  int               cyc = 0;
  logic             core_done = 1'b0;
  logic             stray_done = 1'b0;
  logic [WIDTH-1:0] core_res = '0;
  logic [WIDTH-1:0] stray_val = '0;

  assign bif.done   = core_done | stray_done;
  assign bif.gcd_in = core_done ? core_res : stray_val;

  always @(posedge clk) cyc <= cyc + 1;

  // Subtractive Euclid: core latency is 4 + 3 per subtraction.
  function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                output exp_t e, output int iters);
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    int n;
    x = a;
    y = b;
    n = 0;
    if (a == '0 || b == '0) begin
      e.gcd = a | b;
      e.cycles = '0;
      e.bypass = 1'b1;
    end else begin
      while (x != y) begin
        if (x > y) x = x - y;
        else y = y - x;
        n++;
      end
      e.gcd = x;
      e.cycles = CNT_W'(4 + 3 * n);
      e.bypass = 1'b0;
    end
    iters = n;
  endfunction

  // Core model: done lands on the (4+3n)-th cycle after go; a reset aborts the job.
  initial begin : core
    exp_t e;
    int it;
    bit abort;
    forever begin
      @(negedge clk);
      if (!rst && bif.go === 1'b1) begin
        model(bif.op_a, bif.op_b, e, it);
        abort = 0;
        for (int i = 0; i < 4 + 3 * it; i++) begin
          @(negedge clk);
          if (rst) begin
            abort = 1;
            break;
          end
        end
        if (!abort) begin
          core_res = e.gcd;
          core_done = 1'b1;
          @(negedge clk);
          core_done = 1'b0;
        end
      end
    end
  end

  initial begin : go_mon
    forever begin
      @(negedge clk);
      if (!rst && bif.go === 1'b1) begin
        n_go++;
        last_go = cyc;
      end
    end
  end

  initial begin : out_mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bif.out_valid === 1'b1 && bif.out_ready === 1'b1) begin
        n_out++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_output: got gcd=%0d cycles=%0d bypass=%0b, required no output",
                   bif.out_gcd, bif.out_cycles, bif.out_bypass);
        end else begin
          e = exp_q.pop_front();
          if ({bif.out_gcd, bif.out_cycles, bif.out_bypass} !== e) begin
            n_bad++;
            $display("FAIL result: got gcd=%0d cycles=%0d bypass=%0b, required gcd=%0d cycles=%0d bypass=%0b",
                     bif.out_gcd, bif.out_cycles, bif.out_bypass, e.gcd, e.cycles, e.bypass);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // All tasks start and end one time unit after a rising edge.
  task automatic push_pair(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, output int t);
    exp_t e;
    int it;
    bit ok;
    bif.in_a = a;
    bif.in_b = b;
    bif.in_valid = 1'b1;
    ok = 0;
    t = -1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (bif.in_ready === 1'b1) begin
        ok = 1;
        t = cyc;
        model(a, b, e, it);
        exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    bif.in_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL push_timeout: in_ready never rose for (%0d,%0d)", a, b);
    end
  endtask

  task automatic wait_result(output int v, output logic [WIDTH-1:0] og,
                             output logic [CNT_W-1:0] oc, output logic ob);
    v = -1;
    og = '0;
    oc = '0;
    ob = 1'b0;
    for (int i = 0; i < 200 && v < 0; i++) begin
      @(negedge clk);
      if (bif.out_valid === 1'b1) begin
        v = cyc;
        og = bif.out_gcd;
        oc = bif.out_cycles;
        ob = bif.out_bypass;
      end
    end
    if (v < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL result_timeout: out_valid never rose");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && bif.busy === 1'b0) ok = 1;
    end
    @(posedge clk);
    #1;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d results still pending", exp_q.size());
    end
  endtask

  task automatic test_reset();
    bif.in_valid = 1'b0;
    bif.in_a = '0;
    bif.in_b = '0;
    bif.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bif.go, bif.out_valid, bif.busy, bif.in_ready} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_ctrl: go/out_valid/busy/in_ready=%b, required 0000",
               {bif.go, bif.out_valid, bif.busy, bif.in_ready});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bif.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready: got %b, required 1", bif.in_ready);
    end
    n_cmp++;
    if ({bif.op_a, bif.op_b, bif.out_gcd, bif.out_cycles, bif.out_bypass, bif.busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_values: op_a=%0d op_b=%0d gcd=%0d cycles=%0d bypass=%b busy=%b, required all 0",
               bif.op_a, bif.op_b, bif.out_gcd, bif.out_cycles, bif.out_bypass, bif.busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_equal();
    int t, v, go0;
    logic [WIDTH-1:0] og;
    logic [CNT_W-1:0] oc;
    logic ob;
    bif.out_ready = 1'b1;
    go0 = n_go;
    push_pair(8'd6, 8'd6, t);
    wait_result(v, og, oc, ob);
    n_cmp++;
    if (last_go !== t + 2 || n_go - go0 !== 1) begin
      n_bad++;
      $display("FAIL single_go: go at T+%0d count %0d, required T+2 count 1", last_go - t, n_go - go0);
    end
    n_cmp++;
    if (v !== t + 7) begin
      n_bad++;
      $display("FAIL single_latency: out_valid at T+%0d, required T+7", v - t);
    end
    n_cmp++;
    if ({og, oc, ob} !== {8'd6, 16'd4, 1'b0}) begin
      n_bad++;
      $display("FAIL single_value: gcd=%0d cycles=%0d bypass=%b, required 6/4/0", og, oc, ob);
    end
    drain();
  endtask

  task automatic test_multi_iter();
    int t, v;
    logic [WIDTH-1:0] og;
    logic [CNT_W-1:0] oc;
    logic ob;
    bif.out_ready = 1'b1;
    push_pair(8'd12, 8'd8, t);
    wait_result(v, og, oc, ob);
    n_cmp++;
    if ({og, oc, ob} !== {8'd4, 16'd10, 1'b0}) begin
      n_bad++;
      $display("FAIL multi_12_8: gcd=%0d cycles=%0d bypass=%b, required 4/10/0", og, oc, ob);
    end
    push_pair(8'd35, 8'd14, t);
    wait_result(v, og, oc, ob);
    n_cmp++;
    if (og !== 8'd7) begin
      n_bad++;
      $display("FAIL multi_35_14: gcd=%0d, required 7", og);
    end
    drain();
  endtask

  task automatic test_bypass();
    int t, v, go0;
    logic [WIDTH-1:0] og;
    logic [CNT_W-1:0] oc;
    logic ob;
    bif.out_ready = 1'b1;
    go0 = n_go;
    push_pair(8'd0, 8'd9, t);
    wait_result(v, og, oc, ob);
    n_cmp++;
    if (v !== t + 2 || {og, oc, ob} !== {8'd9, 16'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL bypass_first: valid at T+%0d gcd=%0d cycles=%0d bypass=%b, required T+2 9/0/1",
               v - t, og, oc, ob);
    end
    push_pair(8'd5, 8'd0, t);
    push_pair(8'd0, 8'd0, t);
    drain();
    n_cmp++;
    if (n_go !== go0) begin
      n_bad++;
      $display("FAIL bypass_go: go pulsed %0d times, required 0", n_go - go0);
    end
  endtask

  task automatic test_fifo_full();
    int t[5];
    int out0;
    logic [WIDTH-1:0] as[5];
    logic [WIDTH-1:0] bs[5];
    as = '{8'd20, 8'd7, 8'd0, 8'd9, 8'd16};
    bs = '{8'd5, 8'd7, 8'd4, 8'd6, 8'd12};
    bif.out_ready = 1'b0;
    out0 = n_out;
    for (int i = 0; i < 5; i++) push_pair(as[i], bs[i], t[i]);
    n_cmp++;
    if (t[4] - t[0] !== 4) begin
      n_bad++;
      $display("FAIL fifo_accept: five pushes took %0d cycles, required 4", t[4] - t[0]);
    end
    @(negedge clk);
    n_cmp++;
    if (bif.in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL fifo_full: in_ready=%b with job held and %0d queued, required 0", bif.in_ready, DEPTH);
    end
    repeat (40) @(posedge clk);
    #1;
    n_cmp++;
    if (bif.in_ready !== 1'b0 || bif.out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL fifo_stall: in_ready=%b out_valid=%b, required 0/1", bif.in_ready, bif.out_valid);
    end
    bif.out_ready = 1'b1;
    drain();
    n_cmp++;
    if (n_out - out0 !== 5) begin
      n_bad++;
      $display("FAIL fifo_count: %0d results emerged, required 5", n_out - out0);
    end
  endtask

  task automatic test_reset_mid_wait();
    int t, v;
    bit seen, quiet;
    logic [WIDTH-1:0] og;
    logic [CNT_W-1:0] oc;
    logic ob;
    bif.out_ready = 1'b1;
    push_pair(8'd35, 8'd14, t);
    push_pair(8'd8, 8'd4, t);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bif.go === 1'b1) seen = 1;
    end
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    quiet = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bif.out_valid !== 1'b0 || bif.busy !== 1'b0 || bif.in_ready !== 1'b1) quiet = 0;
    end
    n_cmp++;
    if (!seen || !quiet) begin
      n_bad++;
      $display("FAIL reset_mid_wait: go_seen=%0b quiet_after_reset=%0b, required 1/1", seen, quiet);
    end
    @(posedge clk);
    #1;
    push_pair(8'd9, 8'd3, t);
    wait_result(v, og, oc, ob);
    n_cmp++;
    if ({og, oc} !== {8'd3, 16'd10}) begin
      n_bad++;
      $display("FAIL reset_recover: gcd=%0d cycles=%0d, required 3/10", og, oc);
    end
    drain();
  endtask

  task automatic test_stray_and_stall();
    int t, v, go0;
    bit ok;
    logic [WIDTH-1:0] og;
    logic [CNT_W-1:0] oc;
    logic ob;
    bif.out_ready = 1'b0;
    stray_val = 8'h33;
    stray_done = 1'b1;
    @(posedge clk);
    #1;
    stray_done = 1'b0;
    ok = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bif.out_valid !== 1'b0 || bif.busy !== 1'b0) ok = 0;
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL stray_done_idle: out_valid/busy=%b%b, required 00", bif.out_valid, bif.busy);
    end
    @(posedge clk);
    #1;
    push_pair(8'd15, 8'd10, t);
    wait_result(v, og, oc, ob);
    go0 = n_go;
    ok = 1;
    for (int i = 0; i < 10; i++) begin
      stray_val = 8'hEE;
      stray_done = (i == 4);
      @(negedge clk);
      if (bif.out_valid !== 1'b1 || bif.out_gcd !== og || bif.out_cycles !== oc) ok = 0;
      @(posedge clk);
      #1;
    end
    stray_done = 1'b0;
    n_cmp++;
    if (!ok || n_go !== go0 || {og, oc} !== {8'd5, 16'd10}) begin
      n_bad++;
      $display("FAIL hold_stall: stable=%0b go_pulses=%0d gcd=%0d cycles=%0d, required 1/0/5/10",
               ok, n_go - go0, og, oc);
    end
    bif.out_ready = 1'b1;
    drain();
  endtask

  task automatic test_back_to_back();
    int t, n;
    int v[2];
    bif.out_ready = 1'b1;
    push_pair(8'd6, 8'd6, t);
    push_pair(8'd9, 8'd9, t);
    n = 0;
    v = '{-1, -1};
    for (int i = 0; i < 60 && n < 2; i++) begin
      @(negedge clk);
      if (bif.out_valid === 1'b1) begin
        v[n] = cyc;
        n++;
      end
    end
    n_cmp++;
    if (n !== 2 || v[1] - v[0] !== 7) begin
      n_bad++;
      $display("FAIL back_to_back: %0d results, spacing %0d, required 2 results spaced 7", n, v[1] - v[0]);
    end
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    test_reset();
    test_single_equal();
    test_multi_iter();
    test_bypass();
    test_fifo_full();
    test_reset_mid_wait();
    test_stray_and_stall();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
